fetch_queue: RTL

//  Instruction queue between Fetch and Decode; replaces the plain IF/ID register.

---
 rtl/fetch_queue.sv | 76 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry Fetch->Decode instruction queue with wrong-path flush; entries reach Decode the cycle after push.
// Fetch stalls only when full (never from stall_d_i); Decode back-pressure only fills the queue; a flush empties it and releases Fetch.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [31:0]              instruction_f_i,
  input  logic [31:0]              pc_f_i,
  input  logic [31:0]              pc_plus_4_f_i,
  output logic                     stall_f_o,
  input  logic                     flush_i,
  input  logic                     stall_d_i,
  output logic                     valid_d_o,
  output logic [31:0]              instruction_d_o,
  output logic [31:0]              pc_d_o,
  output logic [31:0]              pc_plus_4_d_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          valid;
  logic          push;
  logic          pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign valid     = (count != '0);
  assign stall_f_o = full && !flush_i;
  assign push      = !full && !flush_i;
  assign pop       = valid && !stall_d_i && !flush_i;

  // Flush discards everything queued; wr_ptr is kept so the next push lands at the new head.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: instruction_f_i, pc: pc_f_i, pc_plus_4: pc_plus_4_f_i};
    end
  end

  assign head = mem[rd_ptr];

  assign valid_d_o       = valid;
  assign instruction_d_o = valid ? head.instr     : NOP_INSTR;
  assign pc_d_o          = valid ? head.pc        : 32'h0;
  assign pc_plus_4_d_o   = valid ? head.pc_plus_4 : 32'h0;
  assign count_o         = count;

endmodule
